alu_issue: RTL and testbench
============================

# alu_issue

Registered issue stage directly upstream of the integer ALU. Accepts one instruction word plus its PC and register-file read values per valid/ready handshake, and decodes OP, OP-IMM, LUI and AUIPC into the ALU's operand/control bundle (in1, in2, func3, opequal) plus writeback tags. Output is fully registered, with a one-entry skid buffer so `in_ready` is a registered signal. Sustains one instruction per cycle with 1-cycle latency.

## Interface
- XLEN, 32, datapath width. Only 32 is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries (branch/trap redirect)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- in_rs1_val  in  32  rs1 register value, already forwarded
- in_rs2_val  in  32  rs2 register value, already forwarded
- out_valid  out  1  output bundle valid
- out_ready  in  1  ALU/writeback stage accepts
- out_in1  out  32  ALU operand 1
- out_in2  out  32  ALU operand 2
- out_func3  out  3  ALU op select
- out_opequal  out  1  SUB/SRA qualifier
- out_rd  out  5  destination register
- out_wen  out  1  register write enable
- out_illegal  out  1  instruction not decodable by this stage

## Operation
Decode (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
- OP 0110011:
  - in1 = rs1_val, in2 = rs2_val, func3 = f3, opequal = instr[30].
  - Legal if f7 = 0000000, or if f7 = 0100000 with f3 ∈ {000, 101}.
- OP-IMM 0010011:
  - in1 = rs1_val, in2 = sign-extended instr[31:20], func3 = f3.
  - opequal = instr[30] only when f3 = 101; otherwise 0. ADDI never subtracts.
  - f3 = 001: legal only if f7 = 0000000.
  - f3 = 101: legal only if f7 ∈ {0000000, 0100000}.
  - All other f3 values are legal.
- LUI 0110111: in1 = 0, in2 = {instr[31:12], 12'b0}, func3 = 000, opequal = 0.
- AUIPC 0010111: in1 = pc, in2 = {instr[31:12], 12'b0}, func3 = 000, opequal = 0.
- Any other opcode, or an illegal encoding:
  - Entry still issues with out_illegal = 1, out_wen = 0.
  - Operands and func3 are as decoded where defined, else 0.
- rd = instr[11:7]. wen = legal && rd != 0.

Buffering (main register M, skid register S):
- Input transfer happens on in_valid && in_ready. Output transfer happens on out_valid && out_ready.
- M empty, or M draining this cycle: decoded input loads M.
- M full and stalled (out_ready = 0): decoded input loads S; in_ready falls next cycle.
- When M drains and S is full: S moves to M, S empties, in_ready rises next cycle.
- in_ready = !S_valid, registered. Never combinationally dependent on out_ready.
- The M payload is held stable while out_valid && !out_ready.
- Order is strictly FIFO. No entry is lost or duplicated.
- flush:
  - M and S are invalidated at the clock edge.
  - Any input transfer in the flush cycle is discarded.
  - out_valid = 0 and in_ready = 1 the following cycle.

## Timing
- Reset (async assert, sync-released use):
  - out_valid = 0, in_ready = 1.
  - All payload outputs are 0.
  - S is empty.
- Latency: an input accepted at edge N appears at out_valid at edge N (registered output visible in cycle N+1).
- Throughput: 1 per cycle with out_ready held high. in_ready never drops in that case.
- Stall: at most 2 entries held. in_ready = 0 exactly while S is valid.
- Reset mid-stream: all entries dropped immediately, independent of clk.
- flush and out_ready both high in the same cycle: the output transfer counts downstream, and the stage is still empty afterwards.

## Test plan
- Streaming, out_ready = 1:
  - `add x3,x1,x2` (0x002081B3), rs1 = 5, rs2 = 7 → next cycle: in1 = 5, in2 = 7, func3 = 000, opequal = 0, rd = 3, wen = 1.
  - Then `sub` (0x402081B3) → opequal = 1, in_ready stays 1.
- Immediates:
  - `addi x1,x0,-1` (0xFFF00093) → in2 = 0xFFFFFFFF, opequal = 0.
  - `srai x1,x1,4` (0x4040D093) → func3 = 101, opequal = 1.
  - `lui x5,0x12345` → in1 = 0, in2 = 0x12345000.
  - `auipc` with pc = 0x100, imm 0x1 → in1 = 0x100, in2 = 0x1000.
- Legality:
  - f7 = 0100000 with f3 = 100 (OP) → out_illegal = 1, wen = 0.
  - opcode 0000011 → out_illegal = 1, wen = 0.
  - `add x0,x1,x2` → out_illegal = 0, wen = 0.
- Backpressure:
  - Hold out_ready = 0 and present 3 back-to-back instructions A, B, C → A in M, B in S.
  - in_ready falls after B, and C waits.
  - Release out_ready → A, B, C emerge in order with no gaps after the first, and the M payload is stable while stalled.
- Flush: with M and S full, assert flush with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, and the flushed-cycle input never appears.
- Async reset: drop rst_n between clock edges during streaming → out_valid = 0 immediately and all outputs 0. After release, the first accepted instruction issues normally.

Source files
------------

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - registered issue stage feeding the integer ALU
// Decodes OP, OP-IMM, LUI and AUIPC into the ALU operand/control bundle.
// Output register M is backed by a one-entry skid register S, so in_ready is registered.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   flush                        synchronous kill of M and S
//   in_valid/in_ready            upstream handshake
//   in_instr/in_pc               instruction word and its address
//   in_rs1_val/in_rs2_val        forwarded register values
//   out_valid/out_ready          downstream handshake
//   out_in1/out_in2              ALU operands
//   out_func3/out_opequal        ALU op select and SUB/SRA qualifier
//   out_rd/out_wen/out_illegal   writeback tag, write enable, undecodable flag
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_in1,
  output logic [XLEN-1:0] out_in2,
  output logic [2:0]      out_func3,
  output logic            out_opequal,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [2:0]      func3;
    logic            opequal;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
  } bundle_t;

  bundle_t dec;
  bundle_t m_data;
  bundle_t s_data;
  logic    m_valid;
  logic    s_valid;
  logic    legal;
  logic    in_fire;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  always_comb begin
    dec         = '0;
    legal       = 1'b0;
    dec.rd      = in_instr[11:7];
    unique case (opcode)
      OPC_OP: begin
        dec.in1     = in_rs1_val;
        dec.in2     = in_rs2_val;
        dec.func3   = f3;
        dec.opequal = in_instr[30];
        legal       = (f7 == F7_ZERO) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        dec.in1     = in_rs1_val;
        dec.in2     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        dec.func3   = f3;
        // Only shifts use bit 30; ADDI with a negative immediate must not subtract.
        dec.opequal = (f3 == 3'b101) && in_instr[30];
        if (f3 == 3'b001)      legal = (f7 == F7_ZERO);
        else if (f3 == 3'b101) legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
        else                   legal = 1'b1;
      end
      OPC_LUI: begin
        dec.in2 = {in_instr[31:12], 12'b0};
        legal   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.in1 = in_pc;
        dec.in2 = {in_instr[31:12], 12'b0};
        legal   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec.illegal = !legal;
    dec.wen     = legal && (in_instr[11:7] != 5'd0);
  end

  // S can only be occupied while M is stalled, so in_ready is simply !S.
  assign in_ready = !s_valid;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || out_ready) begin
      // M is free after this edge: refill from S first to keep FIFO order.
      if (s_valid) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (in_fire) begin
        m_data  <= dec;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_fire) begin
      s_data  <= dec;
      s_valid <= 1'b1;
    end
  end

  assign out_valid   = m_valid;
  assign out_in1     = m_data.in1;
  assign out_in2     = m_data.in2;
  assign out_func3   = m_data.func3;
  assign out_opequal = m_data.opequal;
  assign out_rd      = m_data.rd;
  assign out_wen     = m_data.wen;
  assign out_illegal = m_data.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [2:0]  out_func3;
  logic        out_opequal;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;

  int tests = 0;
  int fails = 0;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_in1(out_in1), .out_in2(out_in2),
    .out_func3(out_func3), .out_opequal(out_opequal),
    .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  func3;
    logic        opequal;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } tb_bundle_t;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [31:0] e_in1, e_in2;
    logic [2:0]  e_f3;
    logic        e_oe;
    logic [4:0]  e_rd;
    logic        e_wen, e_ill;
  } vec_t;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tb_bundle_t got();
    return '{out_in1, out_in2, out_func3, out_opequal, out_rd, out_wen, out_illegal};
  endfunction

  // Reference decode written straight from the instruction-set rules.
  function automatic tb_bundle_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] b);
    tb_bundle_t r;
    int         imm;
    bit         ok;
    logic [6:0] op;
    logic [6:0] f7;
    int         f3;
    r   = '0;
    ok  = 0;
    op  = ins[6:0];
    f7  = ins[31:25];
    f3  = int'(ins[14:12]);
    imm = int'(ins[31:20]);
    if (imm > 2047) imm = imm - 4096;
    r.rd = ins[11:7];
    if (op == 7'h33) begin
      r.in1 = a; r.in2 = b; r.func3 = 3'(f3); r.opequal = ins[30];
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
    end else if (op == 7'h13) begin
      r.in1 = a; r.in2 = 32'(imm); r.func3 = 3'(f3);
      r.opequal = (f3 == 5) ? ins[30] : 1'b0;
      if (f3 == 1)      ok = (f7 == 7'h00);
      else if (f3 == 5) ok = (f7 == 7'h00) || (f7 == 7'h20);
      else              ok = 1;
    end else if (op == 7'h37) begin
      r.in2 = ins & 32'hFFFFF000; ok = 1;
    end else if (op == 7'h17) begin
      r.in1 = pc; r.in2 = ins & 32'hFFFFF000; ok = 1;
    end
    r.illegal = !ok;
    r.wen     = ok && (r.rd != 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1_val = a; in_rs2_val = b;
  endtask

  vec_t       vecs[12];
  tb_bundle_t q[$];
  tb_bundle_t e, hold;
  logic [31:0] ins;
  logic [31:0] opc_tbl[5];
  logic [6:0]  f7r;
  bit          stalled;

  initial begin
    vecs[0]  = '{32'h002081B3, 32'h100, 5, 7, 5, 7, 3'd0, 0, 5'd3, 1, 0};
    vecs[1]  = '{32'h402081B3, 32'h104, 5, 7, 5, 7, 3'd0, 1, 5'd3, 1, 0};
    vecs[2]  = '{32'hFFF00093, 32'h108, 0, 9, 0, 32'hFFFFFFFF, 3'd0, 0, 5'd1, 1, 0};
    vecs[3]  = '{32'h4040D093, 32'h10C, 32'h80, 0, 32'h80, 32'h404, 3'd5, 1, 5'd1, 1, 0};
    vecs[4]  = '{32'h123452B7, 32'h110, 3, 4, 0, 32'h12345000, 3'd0, 0, 5'd5, 1, 0};
    vecs[5]  = '{32'h00001317, 32'h100, 3, 4, 32'h100, 32'h1000, 3'd0, 0, 5'd6, 1, 0};
    vecs[6]  = '{32'h4020C1B3, 32'h118, 5, 7, 5, 7, 3'd4, 1, 5'd3, 0, 1};
    vecs[7]  = '{32'h0000A183, 32'h11C, 5, 7, 0, 0, 3'd0, 0, 5'd3, 0, 1};
    vecs[8]  = '{32'h00208033, 32'h120, 5, 7, 5, 7, 3'd0, 0, 5'd0, 0, 0};
    vecs[9]  = '{32'h40109093, 32'h124, 5, 7, 5, 32'h401, 3'd1, 0, 5'd1, 0, 1};
    vecs[10] = '{32'h40008093, 32'h128, 5, 7, 5, 32'h400, 3'd0, 0, 5'd1, 1, 0};
    vecs[11] = '{32'h0040D093, 32'h12C, 5, 7, 5, 32'h4, 3'd5, 0, 5'd1, 1, 0};

    // Reset state
    #12;
    chk("reset_out_valid", 80'(out_valid), 80'(0));
    chk("reset_in_ready", 80'(in_ready), 80'(1));
    chk("reset_payload", 80'(got()), 80'(0));
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Streaming decode vectors, one per cycle with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      tick();
      chk($sformatf("vec%0d_valid", i), 80'(out_valid), 80'(1));
      chk($sformatf("vec%0d_in_ready", i), 80'(in_ready), 80'(1));
      chk($sformatf("vec%0d_in1", i), 80'(out_in1), 80'(vecs[i].e_in1));
      chk($sformatf("vec%0d_in2", i), 80'(out_in2), 80'(vecs[i].e_in2));
      chk($sformatf("vec%0d_func3", i), 80'(out_func3), 80'(vecs[i].e_f3));
      chk($sformatf("vec%0d_opequal", i), 80'(out_opequal), 80'(vecs[i].e_oe));
      chk($sformatf("vec%0d_rd", i), 80'(out_rd), 80'(vecs[i].e_rd));
      chk($sformatf("vec%0d_wen", i), 80'(out_wen), 80'(vecs[i].e_wen));
      chk($sformatf("vec%0d_illegal", i), 80'(out_illegal), 80'(vecs[i].e_ill));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_empty", 80'(out_valid), 80'(0));

    // Backpressure: A in M, B in S, C waits
    out_ready = 1'b0;
    drive(32'h002081B3, 0, 1, 2);       // A: add x3
    tick();
    chk("bp_a_in_m", 80'(out_valid), 80'(1));
    chk("bp_ready_after_a", 80'(in_ready), 80'(1));
    drive(32'h00A00213, 0, 0, 0);       // B: addi x4,x0,10
    tick();
    chk("bp_ready_low", 80'(in_ready), 80'(0));
    chk("bp_m_is_a", 80'(got()), 80'(ref_model(32'h002081B3, 0, 1, 2)));
    drive(32'h123452B7, 0, 0, 0);       // C: lui x5
    tick();
    chk("bp_still_low", 80'(in_ready), 80'(0));
    chk("bp_m_stable", 80'(got()), 80'(ref_model(32'h002081B3, 0, 1, 2)));
    out_ready = 1'b1;
    tick();
    chk("bp_b_out", 80'(got()), 80'(ref_model(32'h00A00213, 0, 0, 0)));
    chk("bp_b_valid", 80'(out_valid), 80'(1));
    chk("bp_ready_rises", 80'(in_ready), 80'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_c_out", 80'(got()), 80'(ref_model(32'h123452B7, 0, 0, 0)));
    chk("bp_c_valid", 80'(out_valid), 80'(1));
    tick();
    chk("bp_done", 80'(out_valid), 80'(0));

    // Flush with M and S full and an input offered in the flush cycle
    out_ready = 1'b0;
    drive(32'h002081B3, 0, 1, 2); tick();
    drive(32'h402081B3, 0, 1, 2); tick();
    chk("fl_full", 80'(in_ready), 80'(0));
    drive(32'h00100093, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 80'(out_valid), 80'(0));
    chk("fl_in_ready", 80'(in_ready), 80'(1));
    out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", 80'(out_valid), 80'(0));

    // Asynchronous reset between edges while streaming
    drive(32'h002081B3, 0, 5, 7); tick();
    drive(32'h402081B3, 0, 5, 7);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 80'(out_valid), 80'(0));
    chk("ar_payload", 80'(got()), 80'(0));
    chk("ar_in_ready", 80'(in_ready), 80'(1));
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    drive(32'h002081B3, 0, 5, 7); tick();
    in_valid = 1'b0;
    chk("ar_first_valid", 80'(out_valid), 80'(1));
    chk("ar_first", 80'(got()), 80'(ref_model(32'h002081B3, 0, 5, 7)));
    tick();

    // Randomized traffic checked against a FIFO scoreboard
    opc_tbl = '{32'h33, 32'h13, 32'h37, 32'h17, 32'h03};
    q.delete();
    stalled = 0;
    for (int c = 0; c < 3000; c++) begin
      ins = $urandom;
      ins[6:0] = ($urandom_range(0, 5) == 5) ? 7'($urandom) : opc_tbl[$urandom_range(0, 4)][6:0];
      case ($urandom_range(0, 2))
        0: f7r = 7'h00;
        1: f7r = 7'h20;
        default: f7r = 7'($urandom);
      endcase
      ins[31:25] = f7r;
      in_instr = ins; in_pc = $urandom; in_rs1_val = $urandom; in_rs2_val = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);

      chk("rnd_out_valid", 80'(out_valid), 80'(q.size() > 0));
      chk("rnd_in_ready", 80'(in_ready), 80'(q.size() < 2));
      if (stalled && out_valid) chk("rnd_stable", 80'(got()), 80'(hold));
      if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("rnd_payload", 80'(got()), 80'(e));
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(ref_model(in_instr, in_pc, in_rs1_val, in_rs2_val));
      stalled = out_valid && !out_ready && !flush;
      hold = got();
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
